// File: rtl/pipe_pkg.sv
// Shared definitions for the single-slot operand pipeline.
//   pipe_state_e : EMPTY/FULL occupancy encoding of the output register
//   N_IN_MIN/MAX : legal range for the number of selectable inputs
package pipe_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } pipe_state_e;

  localparam int unsigned N_IN_MIN = 2;
  localparam int unsigned N_IN_MAX = 16;

endpackage : pipe_pkg

// File: rtl/mux_n.sv
// Combinational N-way selector.
//   data_in : packed inputs, input k at [k*WIDTH +: WIDTH]
//   sel     : input index
//   data_c  : selected input, zero when sel is out of range
//   oor_c   : high when sel >= N_IN
module mux_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      data_c,
  output logic                  oor_c
);

  // Default to zero/out-of-range; any matching index overrides.
  always_comb begin
    data_c = '0;
    oor_c  = 1'b1;
    for (int k = 0; k < int'(N_IN); k++) begin
      if (sel == SEL_W'(k)) begin
        data_c = data_in[k*WIDTH +: WIDTH];
        oor_c  = 1'b0;
      end
    end
  end

endmodule : mux_n

// File: rtl/ex_operand_mux.sv
// Registered operand selector with a one-deep valid/ready output slot.
//   clk, rst_n          : clock, async active-low reset
//   entradas, sel       : packed operands and index, taken with in_valid
//   in_valid / in_ready : upstream handshake (in_ready is combinational)
//   flush               : drop any held result, blocks a same-cycle accept
//   value / out_valid   : registered result and its valid flag
//   out_ready           : downstream consumes value
//   sel_err / err_clr   : sticky out-of-range-select flag and its clear
module ex_operand_mux
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] entradas,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  input  logic                  err_clr
);

  // Parameter legality checked at elaboration.
  if (int'(SEL_W) != $clog2(N_IN)) begin : g_bad_sel_w
    $error("ex_operand_mux: SEL_W must equal clog2(N_IN)");
  end
  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("ex_operand_mux: N_IN outside legal range");
  end

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             sel_err_q, sel_err_d;
  logic [WIDTH-1:0] mux_data_c;
  logic             mux_oor_c;
  logic             accept_c;

  mux_n #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_mux (
    .data_in (entradas),
    .sel     (sel),
    .data_c  (mux_data_c),
    .oor_c   (mux_oor_c)
  );

  // Slot can take a new operand when empty or being drained this cycle.
  assign in_ready  = (state_q == EMPTY) || out_ready;
  assign accept_c  = in_valid && in_ready && !flush;

  assign out_valid = (state_q == FULL);
  assign value     = value_q;
  assign sel_err   = sel_err_q;

  // Next-state, result and error-flag logic.
  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    sel_err_d = sel_err_q;

    case (state_q)
      EMPTY:   if (accept_c) state_d = FULL;
      FULL:    if (out_ready && !accept_c) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    // Flush wins over everything; value is left untouched.
    if (flush) state_d = EMPTY;

    if (accept_c) value_d = mux_data_c;

    // A new error takes priority over a coincident clear.
    if (accept_c && mux_oor_c) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      value_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      sel_err_q <= sel_err_d;
    end
  end

endmodule : ex_operand_mux

// File: doc/ex_operand_mux.md
EX_OPERAND_MUX -- requirements
Module: ex_operand_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width of each input and of the output.
REQ-002 Parameter N_IN, default 4: number of selectable inputs, legal range 2..16.
REQ-003 Parameter SEL_W, default 2: select width; SHALL equal clog2(N_IN) and is checked at elaboration.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1: asynchronous, active-low reset.
REQ-006 Port entradas  input  N_IN*WIDTH: packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port sel  input  SEL_W: input index, sampled with in_valid.
REQ-008 Port in_valid  input  1: upstream offers entradas/sel this cycle.
REQ-009 Port in_ready  output  1: block accepts this cycle.
REQ-010 Port flush  input  1: discard any held result.
REQ-011 Port value  output  WIDTH: registered selected operand.
REQ-012 Port out_valid  output  1: value holds an unconsumed result.
REQ-013 Port out_ready  input  1: downstream consumes value this cycle.
REQ-014 Port sel_err  output  1: sticky out-of-range-select flag.
REQ-015 Port err_clr  input  1: clears sel_err.

Function
REQ-016 Accept = in_valid && in_ready && !flush; latency from accept to out_valid=1 SHALL be exactly 1 cycle.
REQ-017 in_ready SHALL equal (!out_valid || out_ready), combinational, independent of in_valid.
REQ-018 On accept, value SHALL load entradas[sel*WIDTH +: WIDTH] when sel < N_IN.
REQ-019 On accept with sel >= N_IN (only possible when N_IN < 2^SEL_W), value SHALL load 0 and sel_err SHALL set.
REQ-020 Two states, EMPTY (out_valid=0) and FULL (out_valid=1): EMPTY->FULL on accept; FULL->FULL on accept with out_ready; FULL->EMPTY on out_ready without accept; otherwise hold.
REQ-021 Full throughput: back-to-back accepts with out_ready=1 every cycle SHALL yield one result per cycle, no bubbles.
REQ-022 Stall: out_valid=1 and out_ready=0 SHALL hold value and out_valid unchanged, in_ready=0.
REQ-023 flush SHALL force out_valid=0 next cycle, override any simultaneous accept, and leave value unchanged.
REQ-024 sel_err SHALL stay set until err_clr; simultaneous set and err_clr SHALL leave sel_err=1.
REQ-025 value SHALL change only on accept; no combinational path from entradas or sel to value.

Reset
REQ-026 rst_n low SHALL immediately force out_valid=0, value=0, sel_err=0, regardless of clk.
REQ-027 Reset asserted mid-transfer SHALL drop the held result; no accept SHALL occur in the first rising edge where rst_n is sampled low.
REQ-028 After rst_n deasserts, in_ready SHALL be 1 (state EMPTY).

Structure
REQ-029 Shared package pipe_pkg SHALL hold the EMPTY/FULL state encoding and the N_IN legal-range constants; WIDTH defaults stay local.
REQ-030 The combinational selector SHALL be one sub-module, mux_n (parameters WIDTH, N_IN, SEL_W; out-of-range output 0), with the register and handshake logic in ex_operand_mux.

Verification
REQ-031 Reset then in_valid=1, sel=2, input2=32'hDEAD_BEEF, out_ready=1 -> next cycle value=32'hDEAD_BEEF, out_valid=1.
REQ-032 Streaming sel=0,1,2,3 on consecutive cycles, out_ready=1 -> four consecutive results in order, in_ready=1 throughout.
REQ-033 FULL with out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, value stable; out_ready=1 -> next offered input accepted same cycle.
REQ-034 N_IN=3, accept with sel=3 -> value=0, sel_err=1; err_clr pulse -> sel_err=0; err_clr coincident with another sel=3 accept -> sel_err stays 1.
REQ-035 flush coincident with accept in EMPTY -> out_valid stays 0, value unchanged.
REQ-036 rst_n asserted between clock edges while FULL -> out_valid=0, value=0, sel_err=0 before next edge.
